i2c_slave_regbank: RTL
======================

Name: i2c_slave_regbank

Overview:
Parametrised, system-clocked I2C slave that fronts a NUM_REGS x 8-bit register bank.
- SDA/SCL are oversampled, synchronised and glitch-filtered.
- Supports 7-bit addressing, write with register pointer, sequential read with auto-increment, and repeated START.
- Sits between the board-level open-drain pads and local control logic, which has its own host port into the bank.

Parameters:
- NUM_REGS, 16: number of 8-bit registers; power of two, 2..256.
- PTR_W, $clog2(NUM_REGS): register pointer width.
- FILTER_LEN, 3: consecutive equal samples needed to accept a new SDA/SCL level.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low; asserted when 0, sampled on rising clk.
- scl_in  in  1  SCL pad level.
- sda_in  in  1  SDA pad level.
- sda_oe  out  1  1 = drive SDA low (open-drain); 0 = release.
- slave_addr  in  7  device address; sampled at each START.
- host_we  in  1  host write strobe.
- host_addr  in  PTR_W  host register index.
- host_wdata  in  8  host write data.
- host_rdata  out  8  regs[host_addr], registered, 1-cycle latency.
- busy  out  1  high from addressed ACK to STOP or non-matching repeated START.
- wr_strobe  out  1  one-cycle pulse per I2C data byte written into the bank.
- wr_idx  out  PTR_W  index written, valid with wr_strobe.
- stop_det  out  1  one-cycle pulse on a STOP condition.

Behaviour:
- Reset values:
  - sda_oe=0, busy=0, wr_strobe=0, wr_idx=0, stop_det=0, host_rdata=0.
  - All regs=0, pointer=0, state IDLE, filter outputs=1.
- Input path: 2-flop sync, then filter. Filtered level changes only after FILTER_LEN identical synced samples. Edge detection runs on filtered levels.
  - Input latency to edge detect: 2+FILTER_LEN clk.
  - Required timing: SCL high and low phases each ≥ FILTER_LEN+4 clk.
- Bus conditions:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - Both are recognised in every state and override it. START → ADDR with bit count cleared. STOP → IDLE.
  - sda_oe is released in the same cycle either condition is detected.
- Bit timing:
  - SDA is sampled on the filtered SCL rising edge, MSB first.
  - sda_oe changes only on the cycle after a filtered SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
  - ADDR: after 8 bits, if addr[7:1]==slave_addr, go to ADDR_ACK and drive ACK (sda_oe=1) for one SCL low/high period. Otherwise go to IGNORE: sda_oe=0 until the next START or STOP.
  - After ADDR_ACK:
    - R/W=0 → PTR.
    - R/W=1 → RDATA, with regs[pointer] loaded into the shift register.
  - PTR: received byte[PTR_W-1:0] → pointer. Upper bits are ignored. ACK, then WDATA.
  - WDATA: after 8 bits, write regs[pointer], pulse wr_strobe with wr_idx=pointer, ACK, then pointer += 1.
  - RDATA: shift out; sda_oe = ~bit. At RDATA_ACK, release SDA and sample the master's bit:
    - 0 (ACK): pointer += 1, load next byte, continue in RDATA.
    - 1 (NACK): go to IGNORE.
- Pointer wrap: NUM_REGS-1 increments to 0, for both read and write.
- Repeated START: pointer is retained. A write-then-read (START, write pointer, START, read) reads from that pointer.
- Collision: if host_we and an I2C write hit the same index in the same cycle, the I2C write wins. Different indices both commit.
- Reset mid-transfer: everything returns to reset values immediately and SDA is released. The bus is ignored until the next START.

Decomposition:
- Package i2c_pkg:
  - state enum i2c_state_t.
  - ACK=1'b0, NACK=1'b1.
  - RW_WRITE=1'b0, RW_READ=1'b1.
- Sub-module i2c_sync_filter, instantiated twice (SCL, SDA):
  - Parameter FILTER_LEN.
  - Outputs: filtered level, rise pulse, fall pulse.
- The top level holds the FSM, shift register, pointer and register bank.

Test Plan:
- Write: slave_addr=7'h78; START, 0xF0, 0x03, 0xB3, 0x5A, STOP.
  - Response: ACK on all four bytes; regs[3]=0xB3, regs[4]=0x5A.
  - Two wr_strobe pulses with wr_idx 3 then 4; one stop_det pulse.
- Read with repeated START: after the write above, START, 0xF0, 0x03, Sr, 0xF1; master ACK then NACK; STOP.
  - Response: bytes read 0xB3 then 0x5A; sda_oe=0 after NACK; busy low after STOP.
- Wrap: write pointer 0x0F, then data 0x11, 0x22.
  - Response: regs[15]=0x11, regs[0]=0x22.
  - A read from pointer 0x0F returns 0x11, 0x22.
- Address mismatch: START, 0xA0, 0x01, 0x99, STOP.
  - Response: sda_oe never asserted, no wr_strobe, regs unchanged, busy stays 0.
- Glitch and collision:
  - A 1-clk SCL low glitch mid-byte → no extra bit counted.
  - host_we at index 4 with 0x77, same cycle as an I2C write of 0x5A to index 4 → regs[4]=0x5A.
- Reset mid-transfer: assert reset during the 5th address bit.
  - Response: next cycle sda_oe=0, state IDLE, all regs 0.
  - A subsequent full write transaction completes normally.

Source files
------------

// File: rtl/i2c_slave_regbank_pkg.sv
// Shared types and bus constants for the I2C register-bank slave.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } i2c_state_t;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_sync_filter.sv
// Two-flop synchroniser plus run-length glitch filter with edge pulses.
module i2c_sync_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic in_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          s1_q, s2_q, lvl_q, rise_q, fall_q;
    logic [CW-1:0] cnt_q;
    logic          flip;

    // Accept the new level on the FILTER_LEN-th consecutive differing sample
    assign flip = (s2_q != lvl_q) && (cnt_q == CW'(FILTER_LEN - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            lvl_q  <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= in_i;
            s2_q   <= s1_q;
            rise_q <= flip & s2_q;
            fall_q <= flip & ~s2_q;
            if (s2_q == lvl_q) begin
                cnt_q <= '0;
            end else if (flip) begin
                lvl_q <= s2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = lvl_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave_regbank.sv
// System-clocked I2C slave fronting an 8-bit register bank with a host port.
module i2c_slave_regbank
    import i2c_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int PTR_W      = $clog2(NUM_REGS),
    parameter int FILTER_LEN = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    input  logic [6:0]       slave_addr,
    input  logic             host_we,
    input  logic [PTR_W-1:0] host_addr,
    input  logic [7:0]       host_wdata,
    output logic [7:0]       host_rdata,
    output logic             busy,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_idx,
    output logic             stop_det
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
        .clk(clk), .reset(reset), .in_i(scl_in),
        .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
        .clk(clk), .reset(reset), .in_i(sda_in),
        .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    i2c_state_t       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, nxt_ptr;
    logic [6:0]       addr_q, addr_d;
    logic             oe_q, oe_d, busy_q, busy_d, rw_q, rw_d, ack_q, ack_d;
    logic             wr_q, wr_d, stop_q, stop_d;
    logic [PTR_W-1:0] widx_q, widx_d;
    logic [7:0]       regs_q [NUM_REGS];
    logic [7:0]       rdata_q;
    logic             start_c, stop_c, rx_st, rx_done;

    assign start_c = sda_fall & scl_lvl;
    assign stop_c  = sda_rise & scl_lvl;
    assign nxt_ptr = ptr_q + 1'b1;
    assign rx_st   = (state_q == ADDR) || (state_q == PTR) || (state_q == WDATA);
    assign rx_done = scl_fall && (cnt_q == 4'd8);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        rw_d    = rw_q;
        ack_d   = ack_q;
        widx_d  = widx_q;
        wr_d    = 1'b0;
        stop_d  = 1'b0;
        if (stop_c) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            stop_d  = 1'b1;
        end else if (start_c) begin
            state_d = ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
            addr_d  = slave_addr;
        end else if (rx_st && scl_rise) begin
            shift_d = {shift_q[6:0], sda_lvl};
            cnt_d   = cnt_q + 4'd1;
        end else begin
            unique case (state_q)
                ADDR: if (rx_done) begin
                    cnt_d = '0;
                    if (shift_q[7:1] == addr_q) begin
                        state_d = ADDR_ACK;
                        oe_d    = 1'b1;
                        busy_d  = 1'b1;
                        rw_d    = shift_q[0];
                    end else begin
                        state_d = IGNORE;
                        busy_d  = 1'b0;
                    end
                end
                PTR: if (rx_done) begin
                    cnt_d   = '0;
                    ptr_d   = shift_q[PTR_W-1:0];
                    oe_d    = 1'b1;
                    state_d = PTR_ACK;
                end
                WDATA: if (rx_done) begin
                    cnt_d   = '0;
                    wr_d    = 1'b1;
                    widx_d  = ptr_q;
                    ptr_d   = nxt_ptr;
                    oe_d    = 1'b1;
                    state_d = WDATA_ACK;
                end
                ADDR_ACK: if (scl_fall) begin
                    if (rw_q == RW_READ) begin
                        state_d = RDATA;
                        shift_d = regs_q[ptr_q];
                        oe_d    = ~regs_q[ptr_q][7];
                    end else begin
                        state_d = PTR;
                        oe_d    = 1'b0;
                    end
                end
                PTR_ACK, WDATA_ACK: if (scl_fall) begin
                    state_d = WDATA;
                    oe_d    = 1'b0;
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (rx_done) begin
                        cnt_d   = '0;
                        oe_d    = 1'b0;
                        state_d = RDATA_ACK;
                    end else if (scl_fall) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        oe_d    = ~shift_q[6];
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        ack_d = sda_lvl;
                    end else if (scl_fall) begin
                        if (ack_q == ACK) begin
                            ptr_d   = nxt_ptr;
                            shift_d = regs_q[nxt_ptr];
                            oe_d    = ~regs_q[nxt_ptr][7];
                            state_d = RDATA;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            rw_q    <= RW_WRITE;
            ack_q   <= NACK;
            wr_q    <= 1'b0;
            widx_q  <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            rw_q    <= rw_d;
            ack_q   <= ack_d;
            wr_q    <= wr_d;
            widx_q  <= widx_d;
            stop_q  <= stop_d;
        end
    end

    // I2C write is issued last so it wins a same-index host collision
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            rdata_q <= '0;
        end else begin
            if (host_we) regs_q[host_addr] <= host_wdata;
            if (wr_d)    regs_q[ptr_q] <= shift_q;
            rdata_q <= regs_q[host_addr];
        end
    end

    assign sda_oe     = oe_q;
    assign busy       = busy_q;
    assign wr_strobe  = wr_q;
    assign wr_idx     = widx_q;
    assign stop_det   = stop_q;
    assign host_rdata = rdata_q;

endmodule
